// File: rtl/rans_multilane_decoder.sv
// Multi-lane rANS byte decoder: LANES interleaved states decoded round-robin from one byte
// stream, with internally loaded symbol/frequency/cumulative tables and valid/ready streaming.
module rans_multilane_decoder #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned STATE_W   = 32,
    parameter int unsigned PROB_BITS = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [31:0]          i_num_syms,
    input  logic                 i_tbl_we,
    input  logic [1:0]           i_tbl_sel,
    input  logic [PROB_BITS-1:0] i_tbl_addr,
    input  logic [PROB_BITS:0]   i_tbl_wdata,
    input  logic [7:0]           i_in_data,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    output logic [7:0]           o_out_sym,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int unsigned M_SIZE = 1 << PROB_BITS;
    localparam int unsigned PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BCNT_W = $clog2(4 * LANES);
    localparam logic [STATE_W-1:0] RANS_L = {{(STATE_W-1){1'b0}}, 1'b1} << (STATE_W - 9);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StDecode,
        StRenorm,
        StDrain,
        StDone,
        StError
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Tables are deliberately left out of reset so contents survive a session abort.
    logic [7:0]           r_sym_tbl  [M_SIZE];
    logic [PROB_BITS:0]   r_freq_tbl [256];
    logic [PROB_BITS-1:0] r_cum_tbl  [256];

    logic [STATE_W-1:0] r_x [LANES];
    logic [PTR_W-1:0]   r_ptr;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [31:0]        r_remain;
    logic [7:0]         r_out_sym;
    logic               r_out_valid;
    logic               r_done;
    logic               r_err;

    logic [STATE_W-1:0]   w_x_cur;
    logic [PROB_BITS-1:0] w_slot;
    logic [7:0]           w_sym;
    logic [PROB_BITS:0]   w_freq;
    logic [PROB_BITS-1:0] w_cum;
    logic [STATE_W-1:0]   w_x_dec;
    logic [STATE_W-1:0]   w_x_ren;
    logic [STATE_W-1:0]   w_x_init;
    logic [PTR_W-1:0]     w_init_lane;
    logic [1:0]           w_init_pos;
    logic                 w_init_last;
    logic [PTR_W-1:0]     w_ptr_next;
    logic [31:0]          w_remain_dec;
    logic                 w_fire;
    logic                 w_freq_zero;
    logic                 w_dec_low;
    logic                 w_ren_ok;

    always_ff @(posedge i_clk) begin
        if (i_tbl_we && (r_state == StIdle)) begin
            case (i_tbl_sel)
                2'd0:    r_sym_tbl[i_tbl_addr] <= i_tbl_wdata[7:0];
                2'd1:    r_freq_tbl[i_tbl_addr[7:0]] <= i_tbl_wdata;
                2'd2:    r_cum_tbl[i_tbl_addr[7:0]] <= i_tbl_wdata[PROB_BITS-1:0];
                default: ;
            endcase
        end
    end

    assign w_x_cur      = r_x[r_ptr];
    assign w_slot       = w_x_cur[PROB_BITS-1:0];
    assign w_sym        = r_sym_tbl[w_slot];
    assign w_freq       = r_freq_tbl[w_sym];
    assign w_cum        = r_cum_tbl[w_sym];
    assign w_x_dec      = STATE_W'(w_freq) * (w_x_cur >> PROB_BITS)
                          + STATE_W'(w_slot) - STATE_W'(w_cum);
    assign w_x_ren      = {w_x_cur[STATE_W-9:0], i_in_data};
    assign w_fire       = (r_state == StDecode) && (!r_out_valid || i_out_ready);
    assign w_freq_zero  = (w_freq == '0);
    assign w_dec_low    = (w_x_dec < RANS_L);
    assign w_ren_ok     = (w_x_ren >= RANS_L);
    assign w_ptr_next   = (r_ptr == PTR_W'(LANES - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_remain_dec = r_remain - 32'd1;
    assign w_init_lane  = PTR_W'(r_bcnt >> 2);
    assign w_init_pos   = r_bcnt[1:0];
    assign w_init_last  = (r_bcnt == BCNT_W'(4 * LANES - 1));

    // Little-endian lane load; the first byte of a lane clears any stale upper bits.
    // STATE_W is assumed to be at least 32.
    always_comb begin
        w_x_init = (w_init_pos == 2'd0) ? '0 : r_x[w_init_lane];
        w_x_init[{w_init_pos, 3'b000} +: 8] = i_in_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_busy       = (r_state != StIdle);
        case (r_state)
            StIdle, StError: begin
                if (i_start) begin
                    w_state_next = (i_num_syms == 32'd0) ? StDone : StInit;
                end
            end
            StInit: begin
                o_in_ready = 1'b1;
                if (i_in_valid && w_init_last) begin
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (w_fire) begin
                    if (w_freq_zero) begin
                        w_state_next = StError;
                    end else if (w_dec_low) begin
                        w_state_next = StRenorm;
                    end else if (w_remain_dec == 32'd0) begin
                        w_state_next = StDrain;
                    end
                end
            end
            StRenorm: begin
                o_in_ready = 1'b1;
                if (i_in_valid && w_ren_ok) begin
                    w_state_next = (r_remain == 32'd0) ? StDrain : StDecode;
                end
            end
            StDrain: begin
                // Final symbol may already have been taken while renormalising.
                if (!r_out_valid || i_out_ready) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < LANES; k++) begin
                r_x[k] <= '0;
            end
            r_ptr       <= '0;
            r_bcnt      <= '0;
            r_remain    <= '0;
            r_out_sym   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= (r_state == StDone);
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                StIdle, StError: begin
                    if (i_start) begin
                        r_remain <= i_num_syms;
                        r_err    <= 1'b0;
                        r_ptr    <= '0;
                        r_bcnt   <= '0;
                    end
                end
                StInit: begin
                    if (i_in_valid) begin
                        r_x[w_init_lane] <= w_x_init;
                        r_bcnt           <= r_bcnt + BCNT_W'(1);
                    end
                end
                StDecode: begin
                    if (w_fire) begin
                        r_out_sym   <= w_sym;
                        r_out_valid <= 1'b1;
                        r_remain    <= w_remain_dec;
                        r_x[r_ptr]  <= w_x_dec;
                        if (w_freq_zero) begin
                            r_err <= 1'b1;
                        end else if (!w_dec_low) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                StRenorm: begin
                    if (i_in_valid) begin
                        r_x[r_ptr] <= w_x_ren;
                        if (w_ren_ok) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_sym   = r_out_sym;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_rans_multilane_decoder.sv
// Directed bench for rans_multilane_decoder: table-driven 4-symbol sessions plus
// hand-written sequences for backpressure, zero-frequency error, reset abort and empty session.
module tb_rans_multilane_decoder;

    localparam int LANES     = 2;
    localparam int STATE_W   = 32;
    localparam int PROB_BITS = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num_syms;
    logic        tbl_we;
    logic [1:0]  tbl_sel;
    logic [11:0] tbl_addr;
    logic [12:0] tbl_wdata;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_sym;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    rans_multilane_decoder #(
        .LANES     (LANES),
        .STATE_W   (STATE_W),
        .PROB_BITS (PROB_BITS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_num_syms  (num_syms),
        .i_tbl_we    (tbl_we),
        .i_tbl_sel   (tbl_sel),
        .i_tbl_addr  (tbl_addr),
        .i_tbl_wdata (tbl_wdata),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_sym   (out_sym),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    typedef struct {
        logic [31:0]      x0;
        logic [31:0]      x1;
        logic [2:0][7:0]  rn;
        int               n_rn;
        logic [3:0][7:0]  exp_sym;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   bytes_taken = 0;
    int   done_cnt = 0;
    logic sink_en = 1'b1;
    logic [7:0] feed_q [$];
    logic [7:0] got_q [$];
    vec_t vecs [3];

    // Byte source: handshake is decided at the falling edge since in_ready depends on state only.
    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (feed_q.size() > 0) begin
                in_valid = 1'b1;
                in_data  = feed_q[0];
                if (in_ready) begin
                    void'(feed_q.pop_front());
                    bytes_taken++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = sink_en;
            if (out_valid && out_ready) got_q.push_back(out_sym);
            if (done) done_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tbl_wr(input logic [1:0] sel, input logic [11:0] addr, input logic [12:0] d);
        tbl_we    = 1'b1;
        tbl_sel   = sel;
        tbl_addr  = addr;
        tbl_wdata = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) feed_q.push_back(w[8*b +: 8]);
    endtask

    task automatic start_sess(input logic [31:0] n);
        start    = 1'b1;
        num_syms = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int c0);
        for (int i = 0; i < budget && done_cnt == c0; i++) tick();
        check({name, " done"}, 64'(done_cnt - c0), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int c0;
        feed_q.delete();
        got_q.delete();
        bytes_taken = 0;
        push_word(v.x0);
        push_word(v.x1);
        for (int i = 0; i < v.n_rn; i++) feed_q.push_back(v.rn[i]);
        feed_q.push_back(8'hEE);
        c0 = done_cnt;
        start_sess(32'd4);
        wait_done(name, 200, c0);
        check({name, " count"}, 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s sym%0d", name, i), (i < got_q.size()) ? got_q[i] : 8'hxx,
                  v.exp_sym[i]);
        end
        check({name, " bytes"}, 64'(bytes_taken), 64'(8 + v.n_rn));
        check({name, " idle"}, busy, 1'b0);
        feed_q.delete();
    endtask

    initial begin
        vec_t v1;
        int   c0;

        // a/b table vectors: A two renorms, B no renorm, C double renorm and renorm on last symbol
        vecs[0].x0 = 32'h0080_0800; vecs[0].x1 = 32'h0080_0800;
        vecs[0].rn = {8'h00, 8'h34, 8'h12}; vecs[0].n_rn = 2;
        vecs[0].exp_sym = {8'h61, 8'h61, 8'h62, 8'h62};
        vecs[1].x0 = 32'h1234_5678; vecs[1].x1 = 32'h8765_4321;
        vecs[1].rn = '0; vecs[1].n_rn = 0;
        vecs[1].exp_sym = {8'h61, 8'h62, 8'h61, 8'h61};
        vecs[2].x0 = 32'h0000_1FFF; vecs[2].x1 = 32'h0100_0000;
        vecs[2].rn = {8'hEF, 8'hCD, 8'hAB}; vecs[2].n_rn = 3;
        vecs[2].exp_sym = {8'h61, 8'h62, 8'h61, 8'h62};

        reset = 1'b1; start = 1'b0; num_syms = '0;
        tbl_we = 1'b0; tbl_sel = '0; tbl_addr = '0; tbl_wdata = '0;
        tick();
        tick();
        check("rst busy", busy, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
        check("rst out_sym", out_sym, 8'h00);
        reset = 1'b0;
        tick();

        // Single-symbol table: every slot decodes to 0x41 with full probability
        for (int i = 0; i < 4096; i++) tbl_wr(2'd0, 12'(i), 13'h41);
        tbl_wr(2'd1, 12'h41, 13'd4096);
        tbl_wr(2'd2, 12'h41, 13'd0);
        v1.x0 = 32'h0080_0000; v1.x1 = 32'h0080_0000;
        v1.rn = '0; v1.n_rn = 0;
        v1.exp_sym = {8'h41, 8'h41, 8'h41, 8'h41};
        run_vec(v1, "flat");

        for (int i = 0; i < 4096; i++) tbl_wr(2'd0, 12'(i), (i < 2048) ? 13'h61 : 13'h62);
        tbl_wr(2'd1, 12'h61, 13'd2048);
        tbl_wr(2'd1, 12'h62, 13'd2048);
        tbl_wr(2'd2, 12'h61, 13'd0);
        tbl_wr(2'd2, 12'h62, 13'd2048);
        for (int k = 0; k < 3; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Backpressure: first symbol must hold while the sink stalls
        sink_en = 1'b0;
        tick();
        got_q.delete();
        bytes_taken = 0;
        push_word(32'h0080_0800);
        push_word(32'h0080_0800);
        feed_q.push_back(8'h12);
        feed_q.push_back(8'h34);
        feed_q.push_back(8'hEE);
        c0 = done_cnt;
        start_sess(32'd4);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", out_valid, 1'b1);
            check("bp out_sym", out_sym, 8'h62);
            check("bp in_ready", in_ready, 1'b0);
            check("bp bytes", 64'(bytes_taken), 64'd9);
            tick();
        end
        sink_en = 1'b1;
        wait_done("bp", 200, c0);
        check("bp count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp sym%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx,
                  vecs[0].exp_sym[i]);
        end
        check("bp bytes end", 64'(bytes_taken), 64'd10);
        feed_q.delete();

        // Zero frequency: symbol still emitted, sticky err, stays busy, no done
        tbl_wr(2'd1, 12'h62, 13'd0);
        got_q.delete();
        bytes_taken = 0;
        push_word(32'h0000_0900);
        push_word(32'h0080_0800);
        feed_q.push_back(8'hEE);
        c0 = done_cnt;
        start_sess(32'd4);
        for (int i = 0; i < 50 && !err; i++) tick();
        tick(); tick(); tick();
        check("zf err", err, 1'b1);
        check("zf busy", busy, 1'b1);
        check("zf count", 64'(got_q.size()), 64'd1);
        check("zf sym", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h62);
        check("zf out_valid", out_valid, 1'b0);
        check("zf no done", 64'(done_cnt - c0), 64'd0);
        check("zf bytes", 64'(bytes_taken), 64'd8);
        feed_q.delete();
        start_sess(32'd0);
        check("zf err cleared", err, 1'b0);
        wait_done("zf restart", 10, c0);
        tbl_wr(2'd1, 12'h62, 13'd2048);

        // Reset while stalled in renorm
        got_q.delete();
        bytes_taken = 0;
        push_word(32'h0080_0800);
        push_word(32'h0080_0800);
        c0 = done_cnt;
        start_sess(32'd4);
        for (int i = 0; i < 50 && got_q.size() == 0; i++) tick();
        tick(); tick();
        check("rn stall in_ready", in_ready, 1'b1);
        check("rn stall busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        check("abort busy", busy, 1'b0);
        check("abort in_ready", in_ready, 1'b0);
        check("abort out_valid", out_valid, 1'b0);
        check("abort out_sym", out_sym, 8'h00);
        check("abort err", err, 1'b0);
        check("abort done", done, 1'b0);
        reset = 1'b0;
        tick();
        check("abort no done", 64'(done_cnt - c0), 64'd0);
        run_vec(vecs[0], "retain");

        // Empty session: done two cycles after start, nothing consumed or produced
        feed_q.delete();
        got_q.delete();
        feed_q.push_back(8'hEE);
        bytes_taken = 0;
        c0 = done_cnt;
        start = 1'b1;
        num_syms = 32'd0;
        tick();
        start = 1'b0;
        check("empty busy", busy, 1'b1);
        check("empty done early", done, 1'b0);
        tick();
        check("empty done", done, 1'b1);
        check("empty idle", busy, 1'b0);
        tick();
        check("empty done low", done, 1'b0);
        check("empty bytes", 64'(bytes_taken), 64'd0);
        check("empty syms", 64'(got_q.size()), 64'd0);
        check("empty one pulse", 64'(done_cnt - c0), 64'd1);
        feed_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
